// File: rtl/prng_seq_arb.sv
// prng_seq_arb: seeding sequencer and two-way round-robin arbiter for the
// xorshift256 random stream. Drives the generator's set input for a fixed
// number of cycles, throws away a number of warm-up words, then hands out
// one generator word per cycle to req0/req1 in round-robin order.
module prng_seq_arb #(
  parameter int WIDTH       = 256,
  parameter int SEED_CYCLES = 4,
  parameter int WARMUP      = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] gen_result,
  output logic             gen_set,
  output logic             ready,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] rnd_data,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, SEED, WARM, RUN} state_t;

  // Terminal counts; WARMUP=0 skips WARM entirely, so its value is unused then.
  localparam logic [31:0] SEED_LAST = 32'(SEED_CYCLES - 1);
  localparam logic [31:0] WARM_LAST = 32'((WARMUP > 0) ? (WARMUP - 1) : 0);

  state_t             state_reg, state_next;
  logic [31:0]        cnt_reg, cnt_next;
  logic               ptr_reg, ptr_next;
  logic               gen_set_reg, gen_set_next;
  logic               ready_reg, ready_next;
  logic               gnt0_reg, gnt0_next;
  logic               gnt1_reg, gnt1_next;
  logic [WIDTH-1:0]   rnd_data_reg, rnd_data_next;
  logic [CNT_W-1:0]   word_cnt_reg, word_cnt_next;
  logic               grant0, grant1;

  // State register plus all registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ptr_reg      <= 1'b0;
      gen_set_reg  <= 1'b0;
      ready_reg    <= 1'b0;
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      rnd_data_reg <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ptr_reg      <= ptr_next;
      gen_set_reg  <= gen_set_next;
      ready_reg    <= ready_next;
      gnt0_reg     <= gnt0_next;
      gnt1_reg     <= gnt1_next;
      rnd_data_reg <= rnd_data_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  // Next-state and phase counter; start restarts seeding from any state.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (start) begin
      state_next = SEED;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        SEED: begin
          if (cnt_reg == SEED_LAST) begin
            state_next = (WARMUP == 0) ? RUN : WARM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        WARM: begin
          if (cnt_reg == WARM_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: round-robin grant in RUN, start suppresses any grant.
  always_comb begin
    grant0 = (state_reg == RUN) && !start && req0 && (!req1 || !ptr_reg);
    grant1 = (state_reg == RUN) && !start && req1 && (!req0 ||  ptr_reg);

    gen_set_next  = (state_next == SEED);
    ready_next    = (state_next == RUN);
    gnt0_next     = grant0;
    gnt1_next     = grant1;
    rnd_data_next = rnd_data_reg;
    word_cnt_next = word_cnt_reg;
    ptr_next      = ptr_reg;

    // The winner hands priority to the other requester for the next contest.
    if (grant0) begin
      ptr_next = 1'b1;
    end else if (grant1) begin
      ptr_next = 1'b0;
    end

    if (grant0 || grant1) begin
      rnd_data_next = gen_result;
      word_cnt_next = word_cnt_reg + 1'b1;
    end

    if (start) begin
      word_cnt_next = '0;
    end
  end

  assign gen_set  = gen_set_reg;
  assign ready    = ready_reg;
  assign gnt0     = gnt0_reg;
  assign gnt1     = gnt1_reg;
  assign rnd_data = rnd_data_reg;
  assign word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_prng_seq_arb.sv
// tb_prng_seq_arb: directed test of seeding timing, warm-up, round-robin
// arbitration, restart and asynchronous reset of prng_seq_arb.
module tb_prng_seq_arb;

  localparam int WIDTH = 256;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] gen_result = '0;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic             gen_set, ready, gnt0, gnt1;
  logic [WIDTH-1:0] rnd_data;
  logic [CNT_W-1:0] word_cnt;

  int checks = 0;
  int errors = 0;

  prng_seq_arb #(
    .WIDTH(WIDTH), .SEED_CYCLES(4), .WARMUP(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .gen_result(gen_result),
    .gen_set(gen_set), .ready(ready), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .rnd_data(rnd_data), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk the 4 seed edges and 16 warm-up edges that follow a start edge.
  task automatic seed_and_warm(input string tag);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check({tag, "_seed_gen_set"}, gen_set, 1);
      check({tag, "_seed_nognt"}, gnt0 | gnt1, 0);
    end
    tick();
    check({tag, "_gen_set_drop"}, gen_set, 0);
    check({tag, "_warm_ready"}, ready, 0);
    for (int e = 5; e <= 19; e++) begin
      tick();
      check({tag, "_warm_nognt"}, {ready, gnt0, gnt1}, 0);
    end
    tick();
    check({tag, "_ready_rise"}, ready, 1);
    check({tag, "_ready_nognt"}, gnt0 | gnt1, 0);
  endtask

  initial begin
    logic [1:0] order [4];
    // reset
    #1 rst = 1'b1;
    #2;
    check("rst_gen_set", gen_set, 0);
    check("rst_ready", ready, 0);
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_rnd_data", rnd_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    tick();
    rst = 1'b0;

    // seeding with req1 held early; edge 0 is the start edge
    req1  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("e0_gen_set", gen_set, 1);
    check("e0_ready", ready, 0);
    seed_and_warm("s1");
    // first RUN edge serves the early requester with that edge's word
    gen_result = 256'hAA;
    tick();
    check("early_gnt1", gnt1, 1);
    check("early_gnt0", gnt0, 0);
    check("early_data", rnd_data, 256'hAA);
    check("early_cnt", word_cnt, 1);
    req1 = 1'b0;

    // single requester, three consecutive words (pointer now favours 0)
    req0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      gen_result = WIDTH'(i);
      tick();
      check("single_gnt0", gnt0, 1);
      check("single_gnt1", gnt1, 0);
      check("single_data", rnd_data, WIDTH'(i));
      check("single_cnt", word_cnt, CNT_W'(1 + i));
    end
    req0 = 1'b0;
    gen_result = 256'hDEAD;
    tick();
    check("idle_nognt", {gnt0, gnt1}, 0);
    check("idle_hold_data", rnd_data, 256'h3);

    // contention: last winner was 0, so order is 1,0,1,0
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gen_result = WIDTH'(16 + i);
      tick();
      check("rr_gnt", {gnt0, gnt1}, order[i]);
      check("rr_data", rnd_data, WIDTH'(16 + i));
      check("rr_cnt", word_cnt, CNT_W'(5 + i));
    end
    req1 = 1'b0;

    // restart in RUN with req0 high: start wins the edge
    start = 1'b1;
    gen_result = 256'hBEEF;
    tick();
    start = 1'b0;
    check("restart_nognt", {gnt0, gnt1}, 0);
    check("restart_gen_set", gen_set, 1);
    check("restart_ready", ready, 0);
    check("restart_cnt", word_cnt, 0);
    check("restart_hold_data", rnd_data, WIDTH'(19));
    seed_and_warm("s2");
    gen_result = 256'h77;
    tick();
    check("resume_gnt0", gnt0, 1);
    check("resume_data", rnd_data, 256'h77);
    check("resume_cnt", word_cnt, 1);
    req0 = 1'b0;

    // async reset between edges during WARM
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    check("prerst_warm", {gen_set, ready}, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_gen_set", gen_set, 0);
    check("arst_ready", ready, 0);
    check("arst_gnt", {gnt0, gnt1}, 0);
    check("arst_word_cnt", word_cnt, 0);
    check("arst_rnd_data", rnd_data, 0);
    tick();
    rst = 1'b0;
    // back in IDLE: nothing happens without start, requests ignored
    req0 = 1'b1;
    for (int e = 0; e < 20; e++) tick();
    check("idle_after_rst", {gen_set, ready, gnt0, gnt1}, 0);
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prng_seq_arb.md
Name: prng_seq_arb

Overview:
Controller for the 256-bit PRNG datapath (two SplitMix256 seed generators feeding xorshift256). It sequences seeding by driving the generator's set input, then discards warm-up outputs. Afterwards it shares the one-word-per-cycle random stream between two requesters with a round-robin arbiter. Sits between the xorshift256 instance and the consumers, such as the elliptic-curve scalar logic.

Parameters:
WIDTH, 256, width of the random word and of gen_result/rnd_data
SEED_CYCLES, 4, cycles gen_set is held high per seeding (min 1)
WARMUP, 16, generator outputs discarded after seeding before serving (0 allowed)
CNT_W, 32, width of the delivered-word counter

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: begin or restart the seeding sequence
gen_result  in  WIDTH  current xorshift256 output, a new word every clock when gen_set=0
gen_set  out  1  drives xorshift256 set (load seeds)
ready  out  1  high in RUN state (stream available)
req0  in  1  requester 0 wants a word (level, held until granted)
req1  in  1  requester 1 wants a word
gnt0  out  1  one-cycle pulse: rnd_data belongs to requester 0
gnt1  out  1  one-cycle pulse: rnd_data belongs to requester 1
rnd_data  out  WIDTH  registered random word, valid when gnt0|gnt1
word_cnt  out  CNT_W  words delivered since last seeding, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=IDLE, gen_set=0, ready=0, gnt0=gnt1=0, rnd_data=0, word_cnt=0, priority pointer=0 (req0 favoured), cycle counter=0.
- States: IDLE, SEED, WARM, RUN. All outputs are registered.
- IDLE: waits. start=1 at an edge -> SEED, gen_set=1 from that edge, counter=0.
- SEED: gen_set=1 for exactly SEED_CYCLES cycles. The counter reaching SEED_CYCLES-1 -> WARM, or RUN if WARMUP=0. gen_set drops on the same edge. word_cnt is cleared on entry.
- WARM: gen_set=0. Counts WARMUP edges, ignoring gen_result. Terminal count -> RUN, ready=1.
- RUN: at each edge where req0|req1 is high, grant exactly one requester.
  - Only one requester asserted -> it wins.
  - Both asserted -> the requester selected by the pointer wins, and the pointer moves to the other requester.
  - A single-requester grant also sets the pointer to the other requester.
  - On the grant edge: rnd_data<=gen_result, gntX<=1 for one cycle, word_cnt<=word_cnt+1.
  - Latency: req sampled at edge k -> gnt and rnd_data visible after edge k. The word equals gen_result sampled at edge k.
- Each gen_result word is delivered at most once. Back-to-back grants deliver consecutive generator words.
- A requester still high after its grant competes again at the next edge. If the other requester is also high, the other requester wins that edge.
- rnd_data holds its last value when there is no grant. gnt0 and gnt1 are never high together.
- No grants outside RUN. Requests in IDLE/SEED/WARM are ignored (not queued); req must stay high.
- start in SEED, WARM or RUN -> restart SEED immediately (counter=0, ready=0, gen_set=1). Grants stop on that edge; any grant pulse already issued completes normally. The pointer is not reset.
- start and a request at the same edge in RUN -> start wins, no grant.
- rst asserted mid-operation -> immediate return to reset values, regardless of clock.
- word_cnt wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Reset/seed timing: rst 1->0, start pulse at edge 0 with SEED_CYCLES=4, WARMUP=16 -> gen_set high after edges 0-3, low after edge 4; ready rises after edge 20; no gnt before.
- Single requester: RUN, req0 held 3 cycles, gen_result = 0x..01, 0x..02, 0x..03 on successive edges -> gnt0 pulses 3 times, rnd_data = 01, 02, 03, word_cnt = 3.
- Contention: req0=req1=1 for 4 edges with pointer=0 -> grant order 0, 1, 0, 1; never both gnt high.
- Early request: req1 held through SEED/WARM -> no gnt1 until the first RUN edge, then gnt1 with the gen_result of that edge.
- Restart: start pulse in RUN while req0=1 -> no grant on that edge, gen_set=1 for 4 cycles, ready=0, word_cnt=0; grants resume after warm-up.
- Async reset: rst asserted mid-WARM between clock edges -> gen_set, ready, gnt0/gnt1 and word_cnt go to 0 immediately; state=IDLE.
